// File: rtl/aes_pkg.sv
// Shared AES datapath types: block width and the byte-assembler state encoding.
package aes_pkg;

    localparam int AES_BLK_BYTES = 16;
    localparam int AES_BLK_W     = 128;

    typedef enum logic {
        FILL,
        HOLD
    } asm_state_t;

    typedef logic [AES_BLK_W-1:0] aes_blk_t;

endpackage

// File: rtl/mod_blk_assembler.sv
// Packs bytes popped from the AES input FIFO into one big-endian state block
// and offers it to the round engine over a valid/ready handshake.
module mod_blk_assembler
    import aes_pkg::*;
#(
    parameter int NBYTES = AES_BLK_BYTES,
    parameter int CNT_W  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic [7:0]            fifo_data,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic [8*NBYTES-1:0]   blk_out,
    output logic                  blk_valid,
    input  logic                  blk_ready,
    output logic [CNT_W-1:0]      byte_cnt
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(NBYTES);

    asm_state_t       state;
    asm_state_t       state_nxt;
    logic [CNT_W-1:0] issue_cnt;
    logic             rd_pend;
    logic             rd_en;
    logic             hs;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = FILL;
        end else begin
            unique case (state)
                FILL: if (rd_pend && byte_cnt == LAST) state_nxt = HOLD;
                HOLD: if (blk_ready) state_nxt = FILL;
            endcase
        end
    end

    // Issue is capped by issue_cnt so a byte of the next block is never popped early.
    always_comb begin
        rd_en      = rst && state == FILL && !clr && !fifo_empty && issue_cnt < FULL;
        blk_valid  = state == HOLD;
        hs         = blk_valid && blk_ready;
        fifo_rd_en = rd_en;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blk_out   <= '0;
            byte_cnt  <= '0;
            issue_cnt <= '0;
            rd_pend   <= 1'b0;
        end else if (clr) begin
            byte_cnt  <= '0;
            issue_cnt <= '0;
            rd_pend   <= 1'b0;
        end else begin
            rd_pend <= rd_en;
            if (rd_pend) begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (byte_cnt == CNT_W'(i)) begin
                        blk_out[8*(NBYTES-1-i) +: 8] <= fifo_data;
                    end
                end
                byte_cnt <= byte_cnt + 1'b1;
            end
            if (hs) begin
                byte_cnt  <= '0;
                issue_cnt <= '0;
            end else if (rd_en) begin
                issue_cnt <= issue_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mod_blk_assembler.sv
// Scoreboard bench for mod_blk_assembler driven by a one-cycle-latency FIFO model.
module tb_mod_blk_assembler;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         clr = 1'b0;
    logic [7:0]   fifo_data = 8'h00;
    logic         fifo_empty;
    logic         fifo_rd_en;
    logic [127:0] blk_out;
    logic         blk_valid;
    logic         blk_ready = 1'b0;
    logic [4:0]   byte_cnt;

    logic [7:0]   mem [0:255];
    logic [7:0]   wr_ptr = 8'd0;
    logic [7:0]   rd_ptr = 8'd0;
    int           rd_count = 0;

    logic [127:0] exp_q [$];
    int           n_chk = 0;
    int           n_fail = 0;

    mod_blk_assembler #(.NBYTES(16), .CNT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .blk_out    (blk_out),
        .blk_valid  (blk_valid),
        .blk_ready  (blk_ready),
        .byte_cnt   (byte_cnt)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);

    // FIFO model: registered read data, flushed by reset.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 8'd1;
            rd_count  <= rd_count + 1;
        end
    end

    always @(negedge clk) begin
        if (rst && blk_valid && blk_ready) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_block got=%h", blk_out);
            end else begin
                logic [127:0] e;
                e = exp_q.pop_front();
                if (blk_out !== e) begin
                    n_fail++;
                    $display("FAIL block got=%h exp=%h", blk_out, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic push_seq(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr] = first + 8'(i);
            wr_ptr = wr_ptr + 8'd1;
        end
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            step();
            k++;
        end
        chk("drain", 128'(exp_q.size()), 128'd0);
        step();
    endtask

    initial begin
        int n;
        int rc0;
        int rc16;

        // reset state
        repeat (2) step();
        chk("rst_valid", 128'(blk_valid), 128'd0);
        chk("rst_rd_en", 128'(fifo_rd_en), 128'd0);
        chk("rst_cnt", 128'(byte_cnt), 128'd0);
        chk("rst_blk", blk_out, 128'd0);
        rst = 1'b1;
        step();

        // basic block, latency and pulse count
        blk_ready = 1'b1;
        exp_q.push_back(128'h000102030405060708090A0B0C0D0E0F);
        rc0 = rd_count;
        rc16 = 0;
        push_seq(8'h00, 16);
        n = 0;
        while (!blk_valid && n < 40) begin
            step();
            n++;
            if (n == 16) rc16 = rd_count;
        end
        chk("latency", 128'(n), 128'd17);
        chk("rd_pulses", 128'(rc16 - rc0), 128'd16);
        wait_drain();

        // backpressure: block held, no reads while holding
        blk_ready = 1'b0;
        exp_q.push_back(128'h000102030405060708090A0B0C0D0E0F);
        push_seq(8'h00, 16);
        n = 0;
        while (!blk_valid && n < 40) begin
            step();
            n++;
        end
        push_seq(8'hA0, 5);
        for (int i = 0; i < 10; i++) begin
            chk("hold_valid", 128'(blk_valid), 128'd1);
            chk("hold_blk", blk_out, 128'h000102030405060708090A0B0C0D0E0F);
            chk("hold_rd_en", 128'(fifo_rd_en), 128'd0);
            step();
        end
        blk_ready = 1'b1;
        step();
        chk("hs_drop", 128'(blk_valid), 128'd0);

        // FIFO underrun gap: A0..A4 now, A5..AF later
        repeat (6) step();
        for (int i = 0; i < 8; i++) begin
            chk("gap_cnt", 128'(byte_cnt), 128'd5);
            step();
        end
        exp_q.push_back(128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
        push_seq(8'hA5, 11);
        wait_drain();

        // two back-to-back blocks
        rc0 = rd_count;
        exp_q.push_back(128'h000102030405060708090A0B0C0D0E0F);
        exp_q.push_back(128'h101112131415161718191A1B1C1D1E1F);
        push_seq(8'h00, 32);
        wait_drain();
        chk("two_blk_reads", 128'(rd_count - rc0), 128'd32);

        // clr with the sixth byte in flight
        push_seq(8'h11, 6);
        repeat (6) step();
        chk("pre_clr_cnt", 128'(byte_cnt), 128'd5);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("post_clr_cnt", 128'(byte_cnt), 128'd0);
        chk("post_clr_valid", 128'(blk_valid), 128'd0);
        exp_q.push_back(128'h202122232425262728292A2B2C2D2E2F);
        push_seq(8'h20, 16);
        wait_drain();

        // asynchronous reset mid-block
        push_seq(8'h30, 9);
        n = 0;
        while (byte_cnt != 5'd9 && n < 30) begin
            step();
            n++;
        end
        chk("pre_rst_cnt", 128'(byte_cnt), 128'd9);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_cnt", 128'(byte_cnt), 128'd0);
        chk("arst_blk", blk_out, 128'd0);
        chk("arst_valid", 128'(blk_valid), 128'd0);
        chk("arst_rd_en", 128'(fifo_rd_en), 128'd0);
        step();
        rst = 1'b1;
        step();
        exp_q.push_back(128'h404142434445464748494A4B4C4D4E4F);
        push_seq(8'h40, 16);
        wait_drain();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/mod_blk_assembler.md
Name: mod_blk_assembler

Overview:
- Downstream consumer of the byte-wide AES input FIFO.
- Pops bytes from the FIFO and packs NBYTES consecutive bytes into one 128-bit AES state block.
- Presents the block to the AES round engine with a valid/ready handshake.
- Absorbs the FIFO's one-cycle registered read latency; never over-reads.

Parameters:
- NBYTES, 16, bytes per block. Block width is 8*NBYTES.
- CNT_W, 5, width of the byte counters. Must satisfy 2^CNT_W > NBYTES.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset (0 = reset).
- clr  in  1  synchronous discard of the partial block; active high.
- fifo_data  in  8  FIFO read data, valid the cycle after an accepted rd_en.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO pop request.
- blk_out  out  8*NBYTES  assembled block.
- blk_valid  out  1  blk_out holds a complete block.
- blk_ready  in  1  downstream accepts the block.
- byte_cnt  out  CNT_W  bytes received into the current block.

Behaviour:
- Reset (rst=0, async): state=FILL; blk_out=0; blk_valid=0; fifo_rd_en=0; byte_cnt=0; issue_cnt=0; rd_pend=0.
- States:
  - FILL: collect bytes.
  - HOLD: block complete, blk_valid=1.
- fifo_rd_en is combinational: state==FILL && !clr && !fifo_empty && issue_cnt<NBYTES.
- Each asserted fifo_rd_en increments issue_cnt and sets rd_pend for the next cycle.
- Issue and capture overlap, giving back-to-back reads at 1 byte/cycle.
- Capture: when rd_pend=1, fifo_data is written into byte slot byte_cnt and byte_cnt increments.
- Byte order: byte 0 (first popped) goes to blk_out[8*NBYTES-1 -: 8]; byte NBYTES-1 goes to blk_out[7:0]. This is the AES big-endian state order.
- FILL→HOLD: on the capture edge with byte_cnt==NBYTES-1. blk_valid rises on that edge.
- Latency: with a continuously non-empty FIFO, blk_valid rises NBYTES+1 cycles after the first fifo_rd_en.
- HOLD:
  - fifo_rd_en=0.
  - blk_out and blk_valid are stable until blk_ready=1.
  - On blk_valid && blk_ready: blk_valid=0, byte_cnt=0, issue_cnt=0, state=FILL.
  - A new read can issue the very next cycle.
- blk_ready while in FILL: ignored.
- FIFO empty mid-block: stall with byte_cnt held and partial bytes retained. Resume when fifo_empty drops; no bubbles beyond the empty cycles.
- clr (FILL or HOLD):
  - Next state is FILL with byte_cnt=0, issue_cnt=0, blk_valid=0.
  - rd_pend is cleared, so any in-flight byte is dropped, not captured.
  - blk_out contents are don't-care until the next HOLD.
  - clr has priority over capture and over the handshake.
- Invariant: issue_cnt == byte_cnt + rd_pend, and issue_cnt <= NBYTES. The block never pops a byte belonging to the next block before the handshake.
- Reset mid-block: all state cleared. Bytes already popped are lost, and the FIFO is reset alongside.

Decomposition:
- Package aes_pkg:
  - AES_BLK_BYTES=16
  - AES_BLK_W=128
  - typedef enum logic {FILL, HOLD} asm_state_t
  - typedef logic [AES_BLK_W-1:0] aes_blk_t
- No sub-module. Single always_ff for state/counters/data plus combinational rd_en.

Test Plan:
- Reset, then push 0x00..0x0F into the FIFO with blk_ready=1 → 16 rd_en pulses on consecutive cycles. blk_valid rises 17 cycles after the first rd_en. blk_out=128'h000102030405060708090A0B0C0D0E0F.
- Same stimulus with blk_ready=0 for 10 cycles → blk_valid and blk_out held, fifo_rd_en=0 throughout. After blk_ready=1, blk_valid=0 the next cycle.
- Push 0xA0..0xA4, wait 8 cycles, push 0xA5..0xAF → byte_cnt holds at 5 during the gap. Final blk_out=128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF.
- Push 32 bytes 0x00..0x1F with blk_ready tied to 1 → two blocks: 0x00..0x0F then 0x10..0x1F. The second block has no skipped or duplicated byte.
- Push 0x11..0x16, assert clr for 1 cycle while a read is pending, then push 0x20..0x2F → the first 6 bytes and the in-flight byte are discarded. The next block is 128'h202122232425262728292A2B2C2D2E2F. (Bench drains leftover FIFO bytes accordingly.)
- Assert rst=0 asynchronously with byte_cnt=9 → all outputs go to reset values immediately, without waiting for a clock edge. After release, a full 16-byte push produces a correct block.
